// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB configuration: bus widths, source encodings and default queue depth.
package cdb_arbiter_pkg;

    localparam int NickBus     = 5;
    localparam int DataBus     = 32;
    localparam int AddrBus     = 32;
    localparam int CdbDepthDef = 4;

    localparam logic CDB_SRC_EX  = 1'b0;
    localparam logic CDB_SRC_SLB = 1'b1;

endpackage

// File: rtl/cdb_queue.sv
// Ring-buffer skid queue for one CDB completion source, with synchronous flush.
module cdb_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = CdbDepthDef
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL  = DEPTH;
    localparam logic [PW:0]   C_ONE = 1;
    localparam logic [PW-1:0] P_ONE = 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && (cnt_q != FULL);
    assign pop_ok  = pop_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + P_ONE;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + P_ONE;
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + C_ONE;
                2'b01:   cnt_d = cnt_q - C_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; only entries covered by the count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB result port between EX and SLB completions.
// Optional statistics counters are enabled with `define CDB_STAT_EN.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NICK_W = NickBus,
    parameter int DATA_W = DataBus,
    parameter int ADDR_W = AddrBus,
    parameter int DEPTH  = CdbDepthDef
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iclr,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [DATA_W-1:0] iEX_dt,
    input  logic              iEX_ac,
    input  logic [ADDR_W-1:0] iEX_j_pc,
    output logic              oEX_stall,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oSLB_stall,
    output logic              oCDB_en,
    output logic              oCDB_src,
    output logic [NICK_W-1:0] oCDB_nick,
    output logic [DATA_W-1:0] oCDB_dt,
    output logic              oCDB_ac,
    output logic [ADDR_W-1:0] oCDB_j_pc
`ifdef CDB_STAT_EN
    ,
    output logic [31:0]       oSTAT_conflict,
    output logic [31:0]       oSTAT_stall
`endif
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int EXW  = NICK_W + DATA_W + 1 + ADDR_W;
    localparam int SLBW = NICK_W + DATA_W;
    localparam logic [CW-1:0] FULL = DEPTH;

    logic [CW-1:0]   ex_cnt, slb_cnt;
    logic [EXW-1:0]  ex_head, ex_pay;
    logic [SLBW-1:0] slb_head, slb_pay;
    logic            ex_req, slb_req, ex_hold, slb_hold, ex_cand, slb_cand;
    logic            gnt_ex, gnt_slb, adv, flush;
    logic            ex_push, ex_pop, slb_push, slb_pop;

    logic [NICK_W-1:0] ex_nick, slb_nick;
    logic [DATA_W-1:0] ex_dt, slb_dt;
    logic              ex_ac;
    logic [ADDR_W-1:0] ex_jpc;

    logic              cdb_en_q, cdb_en_d, cdb_src_q, cdb_src_d, cdb_ac_q, cdb_ac_d;
    logic [NICK_W-1:0] cdb_nick_q, cdb_nick_d;
    logic [DATA_W-1:0] cdb_dt_q, cdb_dt_d;
    logic [ADDR_W-1:0] cdb_jpc_q, cdb_jpc_d;
    logic              last_q, last_d;

    assign oEX_stall  = (ex_cnt == FULL);
    assign oSLB_stall = (slb_cnt == FULL);

    // A request presented while its queue is full is simply dropped.
    assign ex_req   = iEX_en && !oEX_stall;
    assign slb_req  = iSLB_en && !oSLB_stall;
    assign ex_hold  = (ex_cnt != '0);
    assign slb_hold = (slb_cnt != '0);
    assign ex_cand  = ex_hold || ex_req;
    assign slb_cand = slb_hold || slb_req;

    assign ex_pay  = ex_hold ? ex_head : {iEX_nick, iEX_dt, iEX_ac, iEX_j_pc};
    assign slb_pay = slb_hold ? slb_head : {iSLB_nick, iSLB_dt};
    assign {ex_nick, ex_dt, ex_ac, ex_jpc} = ex_pay;
    assign {slb_nick, slb_dt}              = slb_pay;

    assign gnt_ex  = ex_cand && (!slb_cand || (last_q == CDB_SRC_SLB));
    assign gnt_slb = slb_cand && !gnt_ex;

    assign adv      = rdy && !iclr;
    assign flush    = rdy && iclr;
    assign ex_pop   = adv && gnt_ex && ex_hold;
    assign slb_pop  = adv && gnt_slb && slb_hold;
    assign ex_push  = adv && ex_req && !(gnt_ex && !ex_hold);
    assign slb_push = adv && slb_req && !(gnt_slb && !slb_hold);

    cdb_queue #(.W(EXW), .DEPTH(DEPTH)) u_ex_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (ex_push),
        .pop_i   (ex_pop),
        .din_i   ({iEX_nick, iEX_dt, iEX_ac, iEX_j_pc}),
        .head_o  (ex_head),
        .count_o (ex_cnt)
    );

    cdb_queue #(.W(SLBW), .DEPTH(DEPTH)) u_slb_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (slb_push),
        .pop_i   (slb_pop),
        .din_i   ({iSLB_nick, iSLB_dt}),
        .head_o  (slb_head),
        .count_o (slb_cnt)
    );

    always_comb begin
        cdb_en_d   = cdb_en_q;
        cdb_src_d  = cdb_src_q;
        cdb_nick_d = cdb_nick_q;
        cdb_dt_d   = cdb_dt_q;
        cdb_ac_d   = cdb_ac_q;
        cdb_jpc_d  = cdb_jpc_q;
        last_d     = last_q;
        if (rdy) begin
            cdb_en_d   = 1'b0;
            cdb_src_d  = 1'b0;
            cdb_nick_d = '0;
            cdb_dt_d   = '0;
            cdb_ac_d   = 1'b0;
            cdb_jpc_d  = '0;
            if (iclr) begin
                last_d = CDB_SRC_SLB;
            end else if (gnt_ex) begin
                cdb_en_d   = 1'b1;
                cdb_src_d  = CDB_SRC_EX;
                cdb_nick_d = ex_nick;
                cdb_dt_d   = ex_dt;
                cdb_ac_d   = ex_ac;
                cdb_jpc_d  = ex_jpc;
                last_d     = CDB_SRC_EX;
            end else if (gnt_slb) begin
                cdb_en_d   = 1'b1;
                cdb_src_d  = CDB_SRC_SLB;
                cdb_nick_d = slb_nick;
                cdb_dt_d   = slb_dt;
                last_d     = CDB_SRC_SLB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_en_q   <= 1'b0;
            cdb_src_q  <= 1'b0;
            cdb_nick_q <= '0;
            cdb_dt_q   <= '0;
            cdb_ac_q   <= 1'b0;
            cdb_jpc_q  <= '0;
            last_q     <= CDB_SRC_SLB;
        end else begin
            cdb_en_q   <= cdb_en_d;
            cdb_src_q  <= cdb_src_d;
            cdb_nick_q <= cdb_nick_d;
            cdb_dt_q   <= cdb_dt_d;
            cdb_ac_q   <= cdb_ac_d;
            cdb_jpc_q  <= cdb_jpc_d;
            last_q     <= last_d;
        end
    end

    assign oCDB_en   = cdb_en_q;
    assign oCDB_src  = cdb_src_q;
    assign oCDB_nick = cdb_nick_q;
    assign oCDB_dt   = cdb_dt_q;
    assign oCDB_ac   = cdb_ac_q;
    assign oCDB_j_pc = cdb_jpc_q;

`ifdef CDB_STAT_EN
    logic [31:0] stat_conf_q, stat_conf_d, stat_stall_q, stat_stall_d;

    // Saturating counters; deliberately untouched by iclr.
    always_comb begin
        stat_conf_d  = stat_conf_q;
        stat_stall_d = stat_stall_q;
        if (rdy && !iclr && ex_cand && slb_cand && (stat_conf_q != '1))
            stat_conf_d = stat_conf_q + 32'd1;
        if (rdy && (oEX_stall || oSLB_stall) && (stat_stall_q != '1))
            stat_stall_d = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_conf_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_conf_q  <= stat_conf_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign oSTAT_conflict = stat_conf_q;
    assign oSTAT_stall    = stat_stall_q;
`else
    // Statistics build option off: no counters or extra ports.
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter; also covers the CDB_STAT_EN counters when that macro is defined.
module tb_cdb_arbiter;

    localparam int NW = 5;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy, iclr;
    logic          iEX_en, iEX_ac, oEX_stall;
    logic [NW-1:0] iEX_nick;
    logic [DW-1:0] iEX_dt;
    logic [AW-1:0] iEX_j_pc;
    logic          iSLB_en, oSLB_stall;
    logic [NW-1:0] iSLB_nick;
    logic [DW-1:0] iSLB_dt;
    logic          oCDB_en, oCDB_src, oCDB_ac;
    logic [NW-1:0] oCDB_nick;
    logic [DW-1:0] oCDB_dt;
    logic [AW-1:0] oCDB_j_pc;
`ifdef CDB_STAT_EN
    logic [31:0]   oSTAT_conflict, oSTAT_stall;
`endif

    always #5 clk = ~clk;

    cdb_arbiter #(.NICK_W(NW), .DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iclr(iclr),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt), .iEX_ac(iEX_ac),
        .iEX_j_pc(iEX_j_pc), .oEX_stall(oEX_stall),
        .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt), .oSLB_stall(oSLB_stall),
        .oCDB_en(oCDB_en), .oCDB_src(oCDB_src), .oCDB_nick(oCDB_nick), .oCDB_dt(oCDB_dt),
        .oCDB_ac(oCDB_ac), .oCDB_j_pc(oCDB_j_pc)
`ifdef CDB_STAT_EN
        , .oSTAT_conflict(oSTAT_conflict), .oSTAT_stall(oSTAT_stall)
`endif
    );

    typedef struct packed {
        logic          en;
        logic          src;
        logic [NW-1:0] nick;
        logic [DW-1:0] dt;
        logic          ac;
        logic [AW-1:0] jpc;
    } cdb_t;

    typedef struct packed {
        logic [NW-1:0] nick;
        logic [DW-1:0] dt;
        logic          ac;
        logic [AW-1:0] jpc;
    } ent_t;

    ent_t  mex[$];
    ent_t  mslb[$];
    cdb_t  sb[$];
    cdb_t  mout;
    logic  mlast;
    int    m_conf, m_stall;
    int    n_chk = 0;
    int    n_pass = 0;
    logic  saw_slb_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mex.delete();
        mslb.delete();
        sb.delete();
        mout   = '0;
        mlast  = 1'b1;
        m_conf = 0;
        m_stall = 0;
    endtask

    task automatic async_reset();
        rdy = 1'b1; iclr = 1'b0; iEX_en = 1'b0; iSLB_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_en", oCDB_en, 0);
        check("rst_nick", oCDB_nick, 0);
        check("rst_dt", oCDB_dt, 0);
        check("rst_ex_stall", oEX_stall, 0);
        check("rst_slb_stall", oSLB_stall, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // One clock: drive, advance the model, push expectation, then compare after the edge.
    task automatic step(input logic r, input logic c, input logic ee, input logic [NW-1:0] enk,
                        input logic [DW-1:0] edt, input logic eac, input logic [AW-1:0] ejp,
                        input logic se, input logic [NW-1:0] snk, input logic [DW-1:0] sdt);
        ent_t e;
        cdb_t x;
        rdy = r; iclr = c;
        iEX_en = ee; iEX_nick = enk; iEX_dt = edt; iEX_ac = eac; iEX_j_pc = ejp;
        iSLB_en = se; iSLB_nick = snk; iSLB_dt = sdt;
        if (r) begin
            if (mex.size() == D || mslb.size() == D) m_stall++;
            if (c) begin
                mex.delete();
                mslb.delete();
                mout  = '0;
                mlast = 1'b1;
            end else begin
                if (ee && mex.size() < D) begin
                    e.nick = enk; e.dt = edt; e.ac = eac; e.jpc = ejp;
                    mex.push_back(e);
                end
                if (se && mslb.size() < D) begin
                    e.nick = snk; e.dt = sdt; e.ac = 1'b0; e.jpc = '0;
                    mslb.push_back(e);
                end
                if (mex.size() > 0 && mslb.size() > 0) m_conf++;
                mout = '0;
                if (mex.size() > 0 && (mslb.size() == 0 || mlast == 1'b1)) begin
                    e = mex.pop_front();
                    mout.en = 1'b1; mout.src = 1'b0; mout.nick = e.nick;
                    mout.dt = e.dt; mout.ac = e.ac; mout.jpc = e.jpc;
                    mlast = 1'b0;
                end else if (mslb.size() > 0) begin
                    e = mslb.pop_front();
                    mout.en = 1'b1; mout.src = 1'b1; mout.nick = e.nick; mout.dt = e.dt;
                    mlast = 1'b1;
                end
            end
        end
        sb.push_back(mout);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("sb_en", oCDB_en, x.en);
        check("sb_src", oCDB_src, x.src);
        check("sb_nick", oCDB_nick, x.nick);
        check("sb_dt", oCDB_dt, x.dt);
        check("sb_ac", oCDB_ac, x.ac);
        check("sb_jpc", oCDB_j_pc, x.jpc);
        check("sb_ex_stall", oEX_stall, mex.size() == D);
        check("sb_slb_stall", oSLB_stall, mslb.size() == D);
        if (oSLB_stall) saw_slb_stall = 1'b1;
    endtask

    task automatic go(input logic r, input logic c, input logic ee, input logic [NW-1:0] en_,
                      input logic se, input logic [NW-1:0] sn);
        step(r, c, ee, en_, 32'hE000_0000 | 32'(en_), en_[0], 32'h8000_0000 | (32'(en_) << 2),
             se, sn, 32'h5000_0000 | 32'(sn));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) go(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        saw_slb_stall = 1'b0;
        model_reset();
        async_reset();

        // 1: idle then single EX request
        idle(1);
        step(1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 32'h0, 1'b0, '0, '0);
        check("t1_en", oCDB_en, 1);
        check("t1_src", oCDB_src, 0);
        check("t1_nick", oCDB_nick, 3);
        check("t1_dt", oCDB_dt, 32'h11);
        idle(2);

        // 2: simultaneous EX/SLB after reset, EX first
        async_reset();
        go(1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 5'd5);
        check("t2_first_src", oCDB_src, 0);
        check("t2_first_nick", oCDB_nick, 4);
        idle(1);
        check("t2_second_src", oCDB_src, 1);
        check("t2_second_nick", oCDB_nick, 5);
        idle(2);

        // 3: sustained dual requests, requester honouring stalls
        async_reset();
        for (int i = 0; i < 8; i++)
            go(1'b1, 1'b0, mex.size() < D, 5'(i + 1), mslb.size() < D, 5'(i + 9));
        check("t3_slb_stall_seen", saw_slb_stall, 1);
        go(1'b1, 1'b0, 1'b1, 5'd20, 1'b1, 5'd21);
        idle(10);

        // 4: flush with three entries queued per source
        async_reset();
        for (int i = 0; i < 6; i++) go(1'b1, 1'b0, 1'b1, 5'(i + 1), 1'b1, 5'(i + 11));
        go(1'b1, 1'b1, 1'b1, 5'd30, 1'b1, 5'd31);
        check("t4_clr_en", oCDB_en, 0);
        check("t4_clr_ex_stall", oEX_stall, 0);
        check("t4_clr_slb_stall", oSLB_stall, 0);
        go(1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 5'd7);
        check("t4_after_clr_src", oCDB_src, 0);
        check("t4_after_clr_nick", oCDB_nick, 6);
        idle(3);

        // 5: rdy low holds the broadcast and the queued SLB entry
        async_reset();
        go(1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd9);
        for (int i = 0; i < 3; i++) begin
            go(1'b0, 1'b0, 1'b1, 5'd12, 1'b1, 5'd13);
            check("t5_hold_nick", oCDB_nick, 7);
            check("t5_hold_en", oCDB_en, 1);
        end
        idle(1);
        check("t5_adv_src", oCDB_src, 1);
        check("t5_adv_nick", oCDB_nick, 9);
        idle(2);

`ifdef CDB_STAT_EN
        // 6: conflict counter survives iclr, clears on rst
        async_reset();
        for (int i = 0; i < 5; i++) go(1'b1, 1'b0, 1'b1, 5'(i + 1), 1'b1, 5'(i + 16));
        check("t6_conflict", oSTAT_conflict, 5);
        go(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        check("t6_conflict_after_clr", oSTAT_conflict, 5);
        async_reset();
        check("t6_conflict_after_rst", oSTAT_conflict, 0);
`endif

        // Randomised traffic including rdy gaps, flushes and stall violations
        async_reset();
        for (int i = 0; i < 120; i++)
            go($urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0,
               1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)),
               1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)));
`ifdef CDB_STAT_EN
        check("rand_stat_conflict", oSTAT_conflict, m_conf);
        check("rand_stat_stall", oSTAT_stall, m_stall);
`endif

        // Async reset with queues busy, then clean restart
        for (int i = 0; i < 5; i++) go(1'b1, 1'b0, 1'b1, 5'(i + 1), 1'b1, 5'(i + 20));
        async_reset();
        go(1'b1, 1'b0, 1'b1, 5'd2, 1'b0, '0);
        check("post_rst_nick", oCDB_nick, 2);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
